// File: rtl/image_convolution_pkg.sv
// Shared sizing defaults, FSM encoding and result count for the 3x3 image convolution block.
// Imported by the convolution core, its image store and the bench.
package image_convolution_pkg;

  localparam int IMG_W_DEF   = 28;
  localparam int IMG_H_DEF   = 28;
  localparam int PIX_W_DEF   = 7;
  localparam int KW_DEF      = 8;
  localparam int ACC_W_DEF   = 20;
  localparam int NUM_TAPS    = 9;
  localparam int NUM_RESULTS = 676;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } conv_state_t;

endpackage

// File: rtl/image_convolution_mem.sv
// Image store: single write port and combinational read that returns 0 above the array.
// Writes take effect on the clock edge, so a same-cycle read still returns the old word.
module image_mem #(
  parameter int DEPTH = 784,
  parameter int PIX_W = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [9:0]       waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [9:0]       raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (waddr < 10'(DEPTH))) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (raddr < 10'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/image_convolution.sv
// Valid-mode 3x3 convolution: 9 MAC clocks + 1 emit clock per result, raster order.
// No backpressure: each result strobes out_valid once and is held until the next one.
module image_convolution
  import image_convolution_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int KW    = KW_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             img_we,
  input  logic [9:0]       img_addr,
  input  logic [PIX_W-1:0] img_wdata,
  output logic [PIX_W-1:0] img_rdata,
  input  logic             k_we,
  input  logic [3:0]       k_addr,
  input  logic [KW-1:0]    k_wdata,
  input  logic             start,
  output logic             busy,
  output logic             out_valid,
  output logic [4:0]       out_row,
  output logic [4:0]       out_col,
  output logic [ACC_W-1:0] out_data,
  output logic             done
);

  localparam int DEPTH = IMG_W * IMG_H;
  localparam int NRES  = (IMG_W - 2) * (IMG_H - 2);

  conv_state_t state;
  logic [3:0]  tap;
  logic [1:0]  ti, tj;
  logic [4:0]  row, col;
  logic [9:0]  base;
  logic [9:0]  res_cnt;
  logic        fin_pend;

  logic [KW-1:0]           kern [NUM_TAPS];
  logic [3:0]              kidx;
  logic [9:0]              core_addr, rd_addr;
  logic [PIX_W-1:0]        mem_rdata;
  logic                    mem_we;
  logic signed [ACC_W-1:0] acc, px_ext, k_ext, prod;

  // The core owns the single read port while busy; the debug read path gets it otherwise.
  assign core_addr = base + 10'(ti) * 10'(IMG_W) + 10'(tj);
  assign rd_addr   = busy ? core_addr : img_addr;
  assign mem_we    = img_we && !busy;
  assign img_rdata = mem_rdata;

  assign kidx   = (tap < 4'(NUM_TAPS)) ? tap : 4'd0;
  assign px_ext = $signed(ACC_W'(mem_rdata));
  assign k_ext  = ACC_W'($signed(kern[kidx]));
  assign prod   = px_ext * k_ext;

  image_mem #(
    .DEPTH (DEPTH),
    .PIX_W (PIX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (img_addr),
    .wdata (img_wdata),
    .raddr (rd_addr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) kern[i] <= '0;
    end else if (k_we && !busy && (k_addr < 4'(NUM_TAPS))) begin
      kern[k_addr] <= k_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_data  <= '0;
      tap       <= '0;
      ti        <= '0;
      tj        <= '0;
      row       <= '0;
      col       <= '0;
      base      <= '0;
      res_cnt   <= '0;
      acc       <= '0;
      fin_pend  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            tap      <= '0;
            ti       <= '0;
            tj       <= '0;
            row      <= '0;
            col      <= '0;
            base     <= '0;
            res_cnt  <= '0;
            acc      <= '0;
            fin_pend <= 1'b0;
          end
        end
        RUN: begin
          if (fin_pend) begin
            state <= FINISH;
            done  <= 1'b1;
          end else if (tap == 4'(NUM_TAPS)) begin
            out_valid <= 1'b1;
            out_data  <= acc;
            out_row   <= row;
            out_col   <= col;
            acc       <= '0;
            tap       <= '0;
            ti        <= '0;
            tj        <= '0;
            res_cnt   <= res_cnt + 10'd1;
            if (res_cnt == 10'(NRES - 1)) begin
              fin_pend <= 1'b1;
            end else if (col == 5'(IMG_W - 3)) begin
              // Skip the two border columns that have no full 3x3 window.
              col  <= '0;
              row  <= row + 5'd1;
              base <= base + 10'd3;
            end else begin
              col  <= col + 5'd1;
              base <= base + 10'd1;
            end
          end else begin
            acc <= acc + prod;
            tap <= tap + 4'd1;
            if (tj == 2'd2) begin
              tj <= '0;
              ti <= ti + 2'd1;
            end else begin
              tj <= tj + 2'd1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_convolution.sv
// Directed and randomized checks of image_convolution against a plain-arithmetic convolution model.
module tb_image_convolution;

  logic              clk;
  logic              rst;
  logic              img_we;
  logic [9:0]        img_addr;
  logic [6:0]        img_wdata;
  logic [6:0]        img_rdata;
  logic              k_we;
  logic [3:0]        k_addr;
  logic [7:0]        k_wdata;
  logic              start;
  logic              busy;
  logic              out_valid;
  logic [4:0]        out_row;
  logic [4:0]        out_col;
  logic signed [19:0] out_data;
  logic              done;

  int total = 0;
  int bad   = 0;

  int img_m [784];
  int k_m   [9];
  int exp_d [676];

  image_convolution dut (
    .clk       (clk),
    .rst       (rst),
    .img_we    (img_we),
    .img_addr  (img_addr),
    .img_wdata (img_wdata),
    .img_rdata (img_rdata),
    .k_we      (k_we),
    .k_addr    (k_addr),
    .k_wdata   (k_wdata),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_data  (out_data),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void compute_expected();
    for (int r = 0; r < 26; r++) begin
      for (int c = 0; c < 26; c++) begin
        int s = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s += img_m[(r + i) * 28 + c + j] * k_m[3 * i + j];
        exp_d[r * 26 + c] = s;
      end
    end
  endfunction

  task automatic write_img(input int a, input int d);
    @(posedge clk); #1;
    k_we = 1'b0; img_we = 1'b1; img_addr = 10'(a); img_wdata = 7'(d);
  endtask

  task automatic write_k(input int a, input int d);
    @(posedge clk); #1;
    img_we = 1'b0; k_we = 1'b1; k_addr = 4'(a); k_wdata = 8'(d);
  endtask

  task automatic end_wr();
    @(posedge clk); #1;
    img_we = 1'b0; k_we = 1'b0;
  endtask

  task automatic load_img();
    for (int a = 0; a < 784; a++) write_img(a, img_m[a]);
    end_wr();
  endtask

  task automatic load_k();
    for (int a = 0; a < 9; a++) write_k(a, k_m[a]);
    end_wr();
  endtask

  task automatic check_mem();
    int errs = 0;
    for (int a = 0; a < 784; a++) begin
      img_addr = 10'(a); #1;
      if (img_rdata !== 7'(img_m[a])) errs++;
    end
    chk("mem_readback_errs", errs, 0);
    img_addr = 10'd784; #1;
    chk("rdata_out_of_range", img_rdata, 0);
  endtask

  task automatic run_conv(input int abort_at, input bit disturb, input bit co_write);
    int n = 0, busy_bad = 0, seen = 0, wa, wd;
    bit fin = 1'b0, aborted = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    if (co_write) begin
      wa = $urandom_range(783); wd = $urandom_range(127);
      img_we = 1'b1; img_addr = 10'(wa); img_wdata = 7'(wd);
      img_m[wa] = wd;
    end
    compute_expected();
    @(posedge clk); #1;
    start = 1'b0; img_we = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 1; cyc <= 7000; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; img_we = 1'b0; k_we = 1'b0;
      if (disturb && (cyc == 500 || cyc == 3001)) begin
        img_we = 1'b1; img_addr = 10'($urandom_range(783)); img_wdata = 7'($urandom_range(127));
        k_we = 1'b1; k_addr = 4'($urandom_range(8)); k_wdata = 8'($urandom_range(255));
        start = 1'b1;
      end
      if (out_valid) begin
        chk("res_coord", {out_row, out_col}, (n / 26) * 32 + n % 26);
        chk("res_data", out_data, (n < 676) ? exp_d[n] : 32'h7fffffff);
        chk("res_cycle", cyc, 10 * (n + 1));
        n++;
        if (n == abort_at) begin
          aborted = 1'b1;
          break;
        end
      end
      if (done) begin
        chk("done_cycle", cyc, 6761);
        chk("result_count", n, 676);
        chk("hold_data", out_data, exp_d[675]);
        chk("hold_coord", {out_row, out_col}, 25 * 32 + 25);
        fin = 1'b1;
        break;
      end else if (!busy) begin
        busy_bad++;
      end
    end
    if (aborted) begin
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_done", done, 0);
      rst = 1'b0;
      repeat (100) begin
        @(posedge clk); #1;
        if (out_valid || done || busy) seen++;
      end
      chk("abort_quiet", seen, 0);
      for (int i = 0; i < 9; i++) k_m[i] = 0;
    end else begin
      chk("run_finished", fin, 1);
      chk("busy_during_run", busy_bad, 0);
      @(posedge clk); #1;
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
    end
  endtask

  initial begin
    rst = 1'b1; img_we = 1'b0; img_addr = '0; img_wdata = '0;
    k_we = 1'b0; k_addr = '0; k_wdata = '0; start = 1'b0;
    for (int i = 0; i < 9; i++) k_m[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;

    // Identity kernel on a flat image.
    for (int a = 0; a < 784; a++) img_m[a] = 1;
    load_img();
    k_m[4] = 1;
    write_k(4, 1); end_wr();
    run_conv(-1, 1'b0, 1'b0);

    // Same-cycle write and read returns the old word until the edge.
    @(posedge clk); #1;
    img_we = 1'b1; img_addr = 10'd5; img_wdata = 7'd3; #1;
    chk("rdw_old", img_rdata, 1);
    @(posedge clk); #1;
    img_we = 1'b0; #1;
    chk("rdw_new", img_rdata, 3);
    img_m[5] = 3;

    // Max pixels with all-one and all-most-negative kernels.
    for (int a = 0; a < 784; a++) img_m[a] = 127;
    load_img();
    for (int i = 0; i < 9; i++) k_m[i] = 1;
    load_k();
    run_conv(-1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) k_m[i] = -128;
    load_k();
    run_conv(-1, 1'b0, 1'b0);

    // Horizontal ramp with a gradient kernel, plus writes and start while busy.
    for (int a = 0; a < 784; a++) img_m[a] = (a % 28) % 128;
    load_img();
    for (int i = 0; i < 9; i++) k_m[i] = (i % 3) - 1;
    load_k();
    run_conv(-1, 1'b1, 1'b0);
    check_mem();

    // Random image and kernel, out-of-range writes, and a write coinciding with start.
    for (int a = 0; a < 784; a++) img_m[a] = $urandom_range(127);
    load_img();
    for (int i = 0; i < 9; i++) k_m[i] = int'($urandom_range(255)) - 128;
    load_k();
    write_img(784, 5);
    write_img(1023, 9);
    write_k(9, 8'h55);
    write_k(15, 8'h7f);
    end_wr();
    run_conv(-1, 1'b0, 1'b1);
    check_mem();

    // Abort mid-run, then confirm the kernel was cleared and the image kept.
    run_conv(100, 1'b0, 1'b0);
    check_mem();
    run_conv(30, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
